// File: rtl/binary_to_gray.sv
// Binary to reflected-Gray converter with a combinational result and a registered,
// valid-qualified copy that flags whether successive accepted codes are Gray-adjacent.
module binary_to_gray #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] binary_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] gray_q,
    output logic             out_valid,
    output logic             adj_ok
);

    logic [WIDTH-1:0] gray_d;
    logic [WIDTH-1:0] diff;
    logic             out_valid_d, out_valid_q;
    logic             adj_ok_d, adj_ok_q;
    logic             have_prev_d, have_prev_q;

    // Pure function of binary_in so the path works with clk/rst idle.
    always_comb begin
        gray_out = binary_in ^ (binary_in >> 1);
    end

    always_comb begin
        diff        = gray_out ^ gray_q;
        gray_d      = gray_q;
        out_valid_d = 1'b0;
        adj_ok_d    = adj_ok_q;
        have_prev_d = have_prev_q;
        if (in_valid) begin
            gray_d      = gray_out;
            out_valid_d = 1'b1;
            adj_ok_d    = have_prev_q && ($countones(diff) == 1);
            have_prev_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gray_q      <= '0;
            out_valid_q <= 1'b0;
            adj_ok_q    <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            gray_q      <= gray_d;
            out_valid_q <= out_valid_d;
            adj_ok_q    <= adj_ok_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign out_valid = out_valid_q;
    assign adj_ok    = adj_ok_q;

endmodule

// File: tb/tb_binary_to_gray.sv
// Directed bench for binary_to_gray: combinational sweep plus a scoreboarded registered path.
module tb_binary_to_gray;

    typedef struct {
        logic [3:0] gray;
        logic       valid;
        logic       adj;
    } exp_t;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] binary_in = '0;
    logic       in_valid = 1'b0;
    logic [3:0] gray_out, gray_q;
    logic       out_valid, adj_ok;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];

    // Reference model state
    logic [3:0] m_gray = '0;
    logic       m_valid = 1'b0;
    logic       m_adj = 1'b0;
    logic       m_have_prev = 1'b0;

    binary_to_gray #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .binary_in (binary_in),
        .in_valid  (in_valid),
        .gray_out  (gray_out),
        .gray_q    (gray_q),
        .out_valid (out_valid),
        .adj_ok    (adj_ok)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        logic [3:0] g;
        g[3] = b[3];
        for (int unsigned i = 0; i < 3; i++) g[i] = b[i+1] ^ b[i];
        return g;
    endfunction

    function automatic int popc(input logic [3:0] x);
        int n = 0;
        for (int unsigned i = 0; i < 4; i++) if (x[i]) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push the model's prediction, and compare it after the edge.
    task automatic step(input logic r, input logic v, input logic [3:0] b);
        exp_t e;
        rst = r;
        in_valid = v;
        binary_in = b;
        #1;
        check("gray_out_live", gray_out, to_gray(b));
        if (r) begin
            m_gray = '0; m_valid = 1'b0; m_adj = 1'b0; m_have_prev = 1'b0;
        end else if (v) begin
            m_adj = m_have_prev && (popc(to_gray(b) ^ m_gray) == 1);
            m_gray = to_gray(b);
            m_valid = 1'b1;
            m_have_prev = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        e.gray = m_gray; e.valid = m_valid; e.adj = m_adj;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("gray_q", gray_q, e.gray);
            check("out_valid", out_valid, e.valid);
            check("adj_ok", adj_ok, e.adj);
        end
    endtask

    logic [3:0] sweep_exp [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                   4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                   4'b1010, 4'b1011, 4'b1001, 4'b1000};

    initial begin
        // Combinational sweep with the clock idle
        for (int i = 0; i < 16; i++) begin
            binary_in = 4'(i);
            #1;
            check("sweep", gray_out, sweep_exp[i]);
            #9;
        end
        #2;
        clk_run = 1'b1;

        // Reset wins over in_valid
        step(1'b1, 1'b1, 4'b0101);
        check("rst_gray_q", gray_q, 4'b0000);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_adj_ok", adj_ok, 1'b0);

        // First accepted value
        step(1'b0, 1'b1, 4'b0101);
        check("first_gray_q", gray_q, 4'b0111);
        check("first_out_valid", out_valid, 1'b1);
        check("first_adj_ok", adj_ok, 1'b0);

        // Counting stream 0..15 then wrap to 0
        step(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'(i));
        step(1'b0, 1'b1, 4'b0000);
        check("wrap_gray_q", gray_q, 4'b0000);
        check("wrap_adj_ok", adj_ok, 1'b1);

        // Repeat and non-adjacent cases
        step(1'b0, 1'b1, 4'b0011);
        step(1'b0, 1'b1, 4'b0011);
        check("repeat_adj_ok", adj_ok, 1'b0);
        step(1'b0, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 4'b0011);
        check("adj_0_3", adj_ok, 1'b1);
        step(1'b0, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 4'b0101);
        check("nonadj_0_5", adj_ok, 1'b0);

        // Gap in in_valid, then resume with the next count value
        step(1'b0, 1'b1, 4'b0110);
        step(1'b0, 1'b1, 4'b0111);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 4'($urandom_range(0, 15)));
            check("gap_out_valid", out_valid, 1'b0);
            check("gap_gray_q", gray_q, 4'b0100);
        end
        step(1'b0, 1'b1, 4'b1000);
        check("resume_adj_ok", adj_ok, 1'b1);

        // Reset mid-stream discards history
        step(1'b0, 1'b1, 4'b1001);
        step(1'b1, 1'b0, 4'b1001);
        step(1'b0, 1'b1, 4'b1010);
        check("post_rst_adj_ok", adj_ok, 1'b0);
        check("post_rst_gray_q", gray_q, 4'b1111);

        // Short random stream against the model
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
